dsc_mul_seq: RTL and testbench
==============================

Name: dsc_mul_seq

Overview:
- Parametrised deterministic stochastic-computing (DSC) multiplier, single clock.
- Replaces the clock-divided two-generator scheme with a single-clock, clock-enable design:
  - the inner counter (stream A) runs every cycle;
  - the outer counter (stream B) advances only when the inner counter wraps.
- Product bits (A AND B) are accumulated into a 2*W-bit binary result.
- Adds a start/busy/done handshake, optional early shutoff once stream B is exhausted, and a selectable stream-A encoding.
- Sits between binary operand registers and downstream datapath logic.

Parameters:
- W, 6: operand width; each stream period is 2^W cycles.
- ES_EN, 1: 1 = early shutoff once stream B goes permanently low; 0 = always run the full 2^(2W) cycles.
- A_ENC, 0: stream-A encoding. 0 = unary, sa = (a_r > ctr_a). 1 = low-discrepancy, sa = (a_r > bitrev(ctr_a)).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while busy=0
- a  in  W  operand A, captured when start is accepted
- b  in  W  operand B, captured when start is accepted
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when z is final
- z  out  2*W  product count; holds until the next accepted start

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; busy=0, done=0, z=0; ctr_a=0, ctr_b=0, a_r=0, b_r=0.
  - Reset has priority over everything, including mid-RUN; the aborted result is lost and no done pulse is issued.
- State IDLE:
  - busy=0.
  - If start=1: a_r<=a, b_r<=b, ctr_a<=0, ctr_b<=0, z<=0, state<=RUN.
  - done is 0 in every cycle except the single cycle after RUN exits.
- State RUN, per cycle, evaluated on current register values:
  - Stream bits: sa per A_ENC; sb = (b_r > ctr_b). Unary in both modes.
  - Early exit: if ES_EN=1 and ctr_b==b_r, then state<=IDLE and done<=1. No accumulation in this cycle.
  - Otherwise:
    - z<=z+(sa&sb); ctr_a<=ctr_a+1 (wraps mod 2^W).
    - If ctr_a==2^W-1: ctr_b<=ctr_b+1.
    - If ctr_a==2^W-1 and ctr_b==2^W-1: state<=IDLE and done<=1. This is full-run completion and occurs only with ES_EN=0.
- start while busy=1 is ignored; a and b are don't-care outside the accept cycle.
- Width and arithmetic:
  - z is 2*W bits, never overflows: max (2^W-1)^2 < 2^(2W).
  - The final z equals a_r*b_r exactly, for both A_ENC values and both ES_EN values.
- Latency, counted from the start-accept edge to the done-high cycle:
  - ES_EN=1: b_r*2^W+2 cycles; RUN lasts b_r*2^W+1 cycles.
  - ES_EN=0: 2^(2W)+1 cycles.
- Boundaries:
  - b=0 with ES_EN=1: RUN lasts 1 cycle, z=0.
  - a=0: full latency still applies, z=0.
  - start=1 in the same cycle that done=1 (state already IDLE) is accepted.
- busy and done are registered with no combinational path from inputs; z is a register output.

Test Plan:
- W=4, ES_EN=1, A_ENC=0; start with a=5, b=3 → busy for 49 cycles; done pulses 50 cycles after the accept edge; z=15, held afterwards.
- W=4, ES_EN=1; a=9, b=0 → busy 1 cycle, done on the next cycle, z=0. Then a=0, b=7 → busy 113 cycles, z=0.
- W=4, ES_EN=0; a=15, b=15 → busy 256 cycles, z=225. Then a=3, b=2 → still busy 256 cycles, z=6.
- W=4, A_ENC=1, ES_EN=1; sweep all 256 (a,b) pairs → z==a*b for every pair; monitor that z increments by at most 1 per cycle.
- W=6 default; a=63, b=40, start; pulse start again with a=1, b=1 at cycle 100 → second request ignored; done after 2562 cycles with z=2520.
- a=10, b=10 at W=4; assert rst at RUN cycle 30 → next cycle busy=0, z=0, no done. New start with a=2, b=3 → z=6.

Source files
------------

// File: rtl/dsc_mul_seq.sv
// Deterministic stochastic-computing multiplier on a single clock.
// Stream A is a fast inner counter; stream B is a slow outer counter that steps
// once per inner wrap. ANDed stream bits are counted into a binary product.
module dsc_mul_seq #(
  parameter int unsigned W     = 6,
  parameter int unsigned ES_EN = 1,
  parameter int unsigned A_ENC = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] z
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [W-1:0]   OneW  = W'(1);
  localparam logic [2*W-1:0] ZeroZ = '0;

  state_e           state_q, state_d;
  logic [W-1:0]     ctr_a_q, ctr_b_q;
  logic [W-1:0]     a_q, b_q;
  logic [2*W-1:0]   z_q;
  logic             done_q, done_d;

  logic             sa, sb, prod_bit;
  logic             last_a, last_b, es_hit;

  // Bit-reversed inner count gives a low-discrepancy stream A
  function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) begin
      r[i] = v[W-1-i];
    end
    return r;
  endfunction

  // Stream bits and run-termination conditions from current register state
  always_comb begin
    sa       = (A_ENC == 1) ? (a_q > bitrev(ctr_a_q)) : (a_q > ctr_a_q);
    sb       = (b_q > ctr_b_q);
    prod_bit = sa & sb;
    last_a   = &ctr_a_q;
    last_b   = &ctr_b_q;
    // Once ctr_b reaches b_r, stream B stays low for the rest of the run
    es_hit   = (ES_EN != 0) && (ctr_b_q == b_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (es_hit || (last_a && last_b)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: busy from state, done registered on the RUN->IDLE transition
  always_comb begin
    busy   = (state_q == StRun);
    done_d = (state_q == StRun) && (state_d == StIdle);
    done   = done_q;
    z      = z_q;
  end

  // Operand capture, stream counters and product accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_a_q <= '0;
      ctr_b_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            ctr_a_q <= '0;
            ctr_b_q <= '0;
            z_q     <= '0;
          end
        end
        StRun: begin
          // The early-exit cycle performs no accumulation
          if (!es_hit) begin
            z_q     <= z_q + {ZeroZ[2*W-1:1], prod_bit};
            ctr_a_q <= ctr_a_q + OneW;
            if (last_a) ctr_b_q <= ctr_b_q + OneW;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed bench for dsc_mul_seq: four parameterisations share clock, reset
// and operand buses; each has its own start line.
module tb_dsc_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start_v = '0;
  logic [5:0]  a_in = '0;
  logic [5:0]  b_in = '0;
  logic [3:0]  busy_v, done_v;
  logic [7:0]  z0, z1, z2;
  logic [11:0] z3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: unary, early shutoff
  dsc_mul_seq #(.W(4), .ES_EN(1), .A_ENC(0)) u_es (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in[3:0]), .b(b_in[3:0]),
    .busy(busy_v[0]), .done(done_v[0]), .z(z0));
  // 1: unary, full run
  dsc_mul_seq #(.W(4), .ES_EN(0), .A_ENC(0)) u_full (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in[3:0]), .b(b_in[3:0]),
    .busy(busy_v[1]), .done(done_v[1]), .z(z1));
  // 2: low-discrepancy, early shutoff
  dsc_mul_seq #(.W(4), .ES_EN(1), .A_ENC(1)) u_ld (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in[3:0]), .b(b_in[3:0]),
    .busy(busy_v[2]), .done(done_v[2]), .z(z2));
  // 3: defaults, W=6
  dsc_mul_seq u_w6 (
    .clk(clk), .rst(rst), .start(start_v[3]), .a(a_in), .b(b_in),
    .busy(busy_v[3]), .done(done_v[3]), .z(z3));

  function automatic int get_z(input int idx);
    case (idx)
      0:       return int'(z0);
      1:       return int'(z1);
      2:       return int'(z2);
      default: return int'(z3);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // z of the low-discrepancy unit may rise by at most one per RUN cycle
  int z2_prev = 0;
  always @(negedge clk) begin
    if (!rst && busy_v[2]) begin
      checks++;
      if (int'(z2) > z2_prev + 1) begin
        errors++;
        $display("FAIL z_step actual=%0d required<=%0d", z2, z2_prev + 1);
      end
    end
    z2_prev = int'(z2);
  end

  // Starts a job (called at a negedge) and returns at the negedge where done is high.
  // lat counts negedges after the accept edge up to and including the done cycle.
  task automatic run(input int idx, input int av, input int bv, input int inj,
                     output int nbusy, output int lat, output bit to);
    bit got;
    a_in  = 6'(av);
    b_in  = 6'(bv);
    start_v[idx] = 1'b1;
    nbusy = 0;
    lat   = 0;
    got   = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 6000 && !got; c++) begin
      @(negedge clk);
      start_v[idx] = (c == inj);
      if (c == inj) begin
        a_in = 6'd1;
        b_in = 6'd1;
      end
      lat = c;
      if (busy_v[idx]) nbusy++;
      if (done_v[idx]) got = 1'b1;
    end
    to = !got;
    if (to) begin
      errors++;
      $display("FAIL timeout dut=%0d actual=no_done required=done", idx);
    end
  endtask

  typedef struct {
    int idx; int a; int b; int inj; int exp_busy; int exp_lat; int exp_z;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nb, lt;
    bit to;

    vecs[0] = '{0, 5, 3, 0, 49, 50, 15};
    vecs[1] = '{0, 9, 0, 0, 1, 2, 0};      // accepted in the previous done cycle
    vecs[2] = '{0, 0, 7, 0, 113, 114, 0};
    vecs[3] = '{1, 15, 15, 0, 256, 257, 225};
    vecs[4] = '{1, 3, 2, 0, 256, 257, 6};
    vecs[5] = '{3, 63, 40, 100, 2561, 2562, 2520};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_busy%0d", i), int'(busy_v[i]), 0);
      chk($sformatf("reset_done%0d", i), int'(done_v[i]), 0);
      chk($sformatf("reset_z%0d", i), get_z(i), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].inj, nb, lt, to);
      chk($sformatf("v%0d_busy", i), nb, vecs[i].exp_busy);
      chk($sformatf("v%0d_lat", i), lt, vecs[i].exp_lat);
      chk($sformatf("v%0d_z", i), get_z(vecs[i].idx), vecs[i].exp_z);
    end

    // done is a single-cycle pulse and z holds afterwards
    @(negedge clk);
    chk("w6_done_pulse", int'(done_v[3]), 0);
    chk("w6_z_hold", int'(z3), 2520);
    repeat (5) @(negedge clk);
    chk("full_z_hold", int'(z1), 6);

    // Reset in the middle of RUN
    a_in = 6'd10;
    b_in = 6'd10;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (29) @(negedge clk);
    chk("abort_busy_before", int'(busy_v[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy_v[0]), 0);
    chk("abort_z", int'(z0), 0);
    chk("abort_done", int'(done_v[0]), 0);
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (done_v[0] || busy_v[0]) seen++;
      end
      chk("abort_quiet", seen, 0);
    end
    run(0, 2, 3, 0, nb, lt, to);
    chk("after_abort_lat", lt, 50);
    chk("after_abort_z", int'(z0), 6);
    @(negedge clk);

    // Low-discrepancy exhaustive sweep
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        run(2, av, bv, 0, nb, lt, to);
        chk($sformatf("ld_z_%0d_%0d", av, bv), int'(z2), av * bv);
        chk($sformatf("ld_lat_%0d_%0d", av, bv), lt, bv * 16 + 2);
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
